fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer that owns the program counter and drives the instruction-memory request/response interface. It moves fetched instructions to decode over a valid/ready handshake and applies EX-stage redirects (taken branch, JAL, JALR). It discards stale in-flight instructions after a redirect. It sits between the IF-stage PC logic, the instruction memory and the F/D boundary.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction word
RESET_PC, 32'hBFC00000, PC value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
redirect_valid  in  1  EX-stage redirect this cycle (taken branch or jump)
redirect_target  in  DATA_WIDTH  redirect destination
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  DATA_WIDTH  fetch address; always equals pcF
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  instruction word returned, one per accepted request
imem_rsp_data  in  DATA_WIDTH  returned instruction
fetch_valid  out  1  instruction available to decode
fetch_ready  in  1  decode accepts (deasserted by hazard unit on stall)
fetch_instr  out  DATA_WIDTH  buffered instruction
fetch_pc  out  DATA_WIDTH  PC of fetch_instr
pcF  out  DATA_WIDTH  current fetch PC
pc_plus4F  out  DATA_WIDTH  pcF + 4
misalign  out  1  one-cycle pulse: redirect_target[1:0] != 0

Behaviour:
- Reset (rst=1 at clock edge): pcF=RESET_PC, state=ISSUE, instruction buffer cleared, misalign=0. Outputs are stable in the cycle after reset: imem_req_valid=1 and fetch_valid=0.
- Only one request is outstanding at a time. The memory returns exactly one response per accepted request, at least 1 cycle after acceptance.
- ISSUE: imem_req_valid=1, imem_req_addr=pcF. The address may change before acceptance; the memory samples it only on the valid&ready cycle.
  - If req_ready and no redirect: go to WAIT.
  - If redirect and req_ready in the same cycle: pcF<=target, go to DRAIN (the accepted request is stale).
  - If redirect and not req_ready: pcF<=target, stay in ISSUE.
- WAIT: imem_req_valid=0.
  - On rsp_valid: capture data into the buffer with fetch_pc<=pcF, go to HOLD.
  - On redirect (with or without rsp_valid in the same cycle): pcF<=target. With rsp_valid, drop the response and go to ISSUE. Without rsp_valid, go to DRAIN.
- DRAIN: imem_req_valid=0 and fetch_valid=0.
  - On rsp_valid: drop the response, go to ISSUE.
  - A further redirect in DRAIN updates pcF to the newest target. It combines with rsp_valid the same way.
- HOLD: fetch_valid = !redirect_valid (the only combinational path from input to fetch_valid). fetch_instr and fetch_pc are stable from the buffer.
  - If fetch_ready and no redirect: pcF<=pcF+4, go to ISSUE.
  - On redirect: the buffer is discarded, pcF<=target, go to ISSUE. Redirect has priority over fetch_ready.
  - Otherwise stay in HOLD; the stall is held indefinitely.
- Redirect target alignment: pcF takes {target[DW-1:2],2'b00}. misalign is registered high for exactly one cycle whenever target[1:0]!=0, in any state.
- Timing: pcF+4 wraps modulo 2^DATA_WIDTH with no error. Best-case throughput is 1 instruction per 3 cycles (ISSUE → WAIT → HOLD).
- Reset asserted mid-transaction: state returns to ISSUE and no DRAIN is performed. The memory subsystem is reset by the same rst and drops its outstanding response.
- imem_rsp_valid in ISSUE or HOLD is a protocol violation. It is ignored and covered by an assertion.

Decomposition:
- fetch_pkg: fetch_state_e enum {ISSUE, WAIT, DRAIN, HOLD}, localparam RESET_PC_DEFAULT, INSTR_NOP = 32'h00000013.
- Sub-module fetch_pc_reg: enable, load, PC register with synchronous reset and a +4 adder. All state logic and the buffer stay in fetch_ctrl.
- Assertions: single outstanding request; fetch_instr stable while fetch_valid && !fetch_ready.

Test Plan:
- Release reset, req_ready=1, rsp 1 cycle later with data=0x00000013, fetch_ready=1 → req_addr=0xBFC00000, fetch_valid with fetch_pc=0xBFC00000, then next req_addr=0xBFC00004.
- In HOLD hold fetch_ready=0 for 5 cycles → fetch_valid stays 1, instr and pc constant, no new request, pcF unchanged.
- Redirect to 0x80000100 in WAIT before the response → state DRAIN, the next rsp is dropped (fetch_valid stays 0), next req_addr=0x80000100.
- Redirect to 0x80000200 in HOLD with fetch_ready=1 in the same cycle → fetch_valid=0 that cycle, no pc+4, next req_addr=0x80000200.
- Redirect to 0x80000302 → pcF=0x80000300, misalign pulses for one cycle.
- Assert rst while in DRAIN → next cycle pcF=0xBFC00000, state ISSUE, fetch_valid=0; pcF=0xFFFFFFFC fetch accepted → next pcF=0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// State encodings are fixed so debug probes and checkers can decode them.
package fetch_pkg;

    localparam int          DATA_WIDTH_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'hBFC00000;
    localparam logic [31:0] INSTR_NOP          = 32'h00000013;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

    // Plain-vector aliases of the enum, used for the state register.
    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program-counter register: synchronous reset, load has priority
// over the +4 increment, which wraps modulo 2^DATA_WIDTH.
module fetch_pc_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_pc,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);

    logic [DATA_WIDTH-1:0] pc_q;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= load_pc;
        end else if (en) begin
            pc_q <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues one imem request at a time, buffers the
// returned word for decode and squashes in-flight fetches on EX redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic [DATA_WIDTH-1:0] fetch_pc,
    output logic [DATA_WIDTH-1:0] pcF,
    output logic [DATA_WIDTH-1:0] pc_plus4F,
    output logic                  misalign,
    output logic [1:0]            state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and a response is only legal in WAIT/DRAIN.

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] instr_pc_q;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] target_aligned;
    logic                  pc_advance;
    logic                  capture;

    assign target_aligned = {redirect_target[DATA_WIDTH-1:2], 2'b00};
    assign pc_advance     = (state_q == ST_HOLD) && fetch_ready && !redirect_valid;
    assign capture        = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;

    fetch_pc_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .en       (pc_advance),
        .load     (redirect_valid),
        .load_pc  (target_aligned),
        .pc       (pcF),
        .pc_plus4 (pc_plus4F)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ISSUE: begin
                if (imem_req_ready) begin
                    state_d = redirect_valid ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = redirect_valid ? ST_ISSUE : ST_HOLD;
                end else if (redirect_valid) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_HOLD: begin
                // Redirect and consume both leave for ISSUE; only a stall stays.
                if (redirect_valid || fetch_ready) begin
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ISSUE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= redirect_valid && is_misaligned(redirect_target[1:0]);
            if (capture) begin
                instr_q    <= imem_rsp_data;
                instr_pc_q <= pcF;
            end
        end
    end

    assign imem_req_valid = (state_q == ST_ISSUE);
    assign imem_req_addr  = pcF;
    assign fetch_valid    = (state_q == ST_HOLD) && !redirect_valid;
    assign fetch_instr    = instr_q;
    assign fetch_pc       = instr_pc_q;
    assign misalign       = misalign_q;
    assign state_dbg      = state_q;

    a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
        (imem_req_valid && imem_req_ready) |=> !imem_req_valid);

    a_rsp_only_when_pending: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (state_q == ST_WAIT || state_q == ST_DRAIN));

    a_instr_stable_on_stall: assert property (@(posedge clk) disable iff (rst)
        (fetch_valid && !fetch_ready) |=> ($stable(fetch_instr) && $stable(fetch_pc)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// randomized traffic against an abstract pending/stale/buffered model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        misalign;
    logic [1:0]  state_dbg;

    int checks   = 0;
    int failures = 0;

    // Abstract model: outstanding request, whether it is stale, buffered word.
    bit          model_ok = 0;
    logic [31:0] m_pc;
    bit          m_out, m_stale, m_have, m_mis;
    logic [31:0] m_buf, m_buf_pc;

    // Memory model: one pending response with a countdown latency.
    bit          mem_pending = 0;
    int          mem_delay   = 0;
    int          mem_lat     = 0;
    bit          mem_rand    = 0;
    bit          dir_data    = 1;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .pcF             (pcF),
        .pc_plus4F       (pc_plus4F),
        .misalign        (misalign),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_have) return 2'(HOLD);
        if (m_out)  return m_stale ? 2'(DRAIN) : 2'(WAIT);
        return 2'(ISSUE);
    endfunction

    // Compare, then advance model and memory with this cycle's inputs.
    always @(negedge clk) begin
        bit acc;
        logic [31:0] pc_old;
        if (model_ok) begin
            chk("req_valid", 32'(imem_req_valid), 32'(!m_out && !m_have));
            chk("req_addr", imem_req_addr, m_pc);
            chk("pcF", pcF, m_pc);
            chk("pc_plus4F", pc_plus4F, m_pc + 32'd4);
            chk("fetch_valid", 32'(fetch_valid), 32'(m_have && !redirect_valid));
            chk("misalign", 32'(misalign), 32'(m_mis));
            chk("state", 32'(state_dbg), 32'(m_state()));
            if (m_have) begin
                chk("fetch_instr", fetch_instr, m_buf);
                chk("fetch_pc", fetch_pc, m_buf_pc);
            end
        end
        if (rst) begin
            m_pc = 32'hBFC00000;
            m_out = 0; m_stale = 0; m_have = 0; m_mis = 0;
            model_ok = 1;
            mem_pending = 0;
        end else if (model_ok) begin
            acc    = !m_out && !m_have && imem_req_ready;
            pc_old = m_pc;
            m_mis  = redirect_valid && (redirect_target[1:0] != 2'b00);
            if (m_have && redirect_valid) m_have = 0;
            else if (m_have && fetch_ready) begin
                m_have = 0;
                m_pc = pc_old + 32'd4;
            end
            if (m_out && imem_rsp_valid) begin
                m_out = 0;
                if (!m_stale && !redirect_valid) begin
                    m_have = 1; m_buf = imem_rsp_data; m_buf_pc = pc_old;
                end
                m_stale = 0;
            end else if (m_out && redirect_valid) begin
                m_stale = 1;
            end
            if (acc) begin
                m_out = 1; m_stale = redirect_valid;
            end
            if (redirect_valid) m_pc = {redirect_target[31:2], 2'b00};
            if (imem_rsp_valid) mem_pending = 0;
            if (imem_req_valid && imem_req_ready) begin
                mem_pending = 1;
                mem_delay   = mem_rand ? $urandom_range(0, 3) : mem_lat;
            end
        end
    end

    task automatic step(input bit r, input bit rd, input logic [31:0] tg,
                        input bit rq, input bit fr);
        @(posedge clk);
        #1;
        rst = r; redirect_valid = rd; redirect_target = tg;
        imem_req_ready = rq; fetch_ready = fr;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if (!r && mem_pending) begin
            if (mem_delay == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = dir_data ? INSTR_NOP : $urandom;
            end else begin
                mem_delay--;
            end
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tg;
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        chk("lit_reset_pc", pcF, 32'hBFC00000);
        chk("lit_reset_fv", 32'(fetch_valid), 32'd0);
        // Basic fetch with a one-cycle memory.
        step(0, 0, 0, 1, 1);
        chk("lit_first_addr", imem_req_addr, 32'hBFC00000);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("lit_fetch_valid", 32'(fetch_valid), 32'd1);
        chk("lit_fetch_pc", fetch_pc, 32'hBFC00000);
        chk("lit_fetch_instr", fetch_instr, 32'h00000013);
        step(0, 0, 0, 0, 1);
        chk("lit_next_addr", imem_req_addr, 32'hBFC00004);
        // Decode stall held for five cycles.
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 1, 0);
            chk("lit_stall_fv", 32'(fetch_valid), 32'd1);
            chk("lit_stall_pc", pcF, 32'hBFC00004);
        end
        step(0, 0, 0, 0, 1);
        // Redirect in WAIT before the response arrives.
        mem_lat = 2;
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h80000100, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_drain_state", 32'(state_dbg), 32'(DRAIN));
        step(0, 0, 0, 0, 1);
        chk("lit_drain_fv", 32'(fetch_valid), 32'd0);
        mem_lat = 0;
        step(0, 0, 0, 1, 1);
        chk("lit_redir_addr", imem_req_addr, 32'h80000100);
        // Redirect in HOLD racing fetch_ready.
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h80000200, 1, 1);
        chk("lit_hold_redir_fv", 32'(fetch_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("lit_hold_redir_addr", imem_req_addr, 32'h80000200);
        // Misaligned target.
        step(0, 1, 32'h80000302, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_mis_pc", pcF, 32'h80000300);
        chk("lit_mis_hi", 32'(misalign), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("lit_mis_lo", 32'(misalign), 32'd0);
        // Reset while draining.
        mem_lat = 2;
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h80000400, 0, 1);
        step(1, 0, 0, 0, 1);
        chk("lit_rst_drain_st", 32'(state_dbg), 32'(DRAIN));
        step(0, 0, 0, 0, 1);
        chk("lit_rst_pc", pcF, 32'hBFC00000);
        chk("lit_rst_state", 32'(state_dbg), 32'(ISSUE));
        // PC wrap at the top of the address space.
        mem_lat = 0;
        step(0, 1, 32'hFFFFFFFC, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("lit_wrap_addr", imem_req_addr, 32'hFFFFFFFC);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_wrap_fpc", fetch_pc, 32'hFFFFFFFC);
        chk("lit_wrap_p4", pc_plus4F, 32'h00000000);
        step(0, 0, 0, 0, 1);
        chk("lit_wrap_pc", pcF, 32'h00000000);
        // Randomized traffic.
        mem_rand = 1;
        dir_data = 0;
        for (int i = 0; i < 4000; i++) begin
            tg = $urandom;
            if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, tg,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
